// File: rtl/tmr_slave_if.sv
// dbus slave-side bus bundle: decoder select, address, strobes and data.
// The master modport drives the request; the slave modport returns rdata.
interface tmr_slave_if #(
   parameter int NSLAVES = 3,
   parameter int DW      = 8
) ();
   logic [NSLAVES-1:0] sel;
   logic [1:0]         adr;
   logic               we;
   logic               re;
   logic [DW-1:0]      wdata;
   logic [DW-1:0]      rdata;

   modport master (output sel, adr, we, re, wdata, input rdata);
   modport slave  (input sel, adr, we, re, wdata, output rdata);
endinterface

// File: rtl/tmr_slave.sv
// 8-bit timer/counter dbus slave: prescaler, free-run or clear-on-compare,
// W1C overflow/compare flags with level irq, and a registered PWM output.
module tmr_slave #(
   parameter int ID      = 3,
   parameter int NSLAVES = 3,
   parameter int DW      = 8
) (
   input  logic          i_clk,
   input  logic          i_rst,
   tmr_slave_if.slave    bus,
   output logic          o_irq,
   output logic          o_pwm
);
   logic [5:0]    r_ctrl;
   logic [DW-1:0] r_cnt;
   logic [DW-1:0] r_cmp;
   logic          r_ovf;
   logic          r_cmf;
   logic [7:0]    r_pcnt;
   logic [DW-1:0] r_rdata;
   logic          r_irq;
   logic          r_pwm;

   logic          w_sel;
   logic          w_wr;
   logic          w_rd;
   logic          w_wr_ctrl;
   logic          w_wr_cnt;
   logic          w_wr_cmp;
   logic          w_wr_flg;
   logic [7:0]    w_div_m1;
   logic          w_tick;
   logic [7:0]    w_pcnt_nxt;
   logic [DW-1:0] w_cnt_nxt;
   logic          w_ovf_set;
   logic          w_cmf_set;
   logic [5:0]    w_ctrl_nxt;
   logic [DW-1:0] w_cmp_nxt;
   logic          w_ovf_nxt;
   logic          w_cmf_nxt;
   logic [DW-1:0] w_rd_mux;

   // An ID outside the select vector leaves the slave permanently unselected.
   if (ID < NSLAVES) begin : g_sel
      assign w_sel = bus.sel[ID];
   end else begin : g_nosel
      assign w_sel = 1'b0;
   end

   assign w_wr      = w_sel & bus.we;
   assign w_rd      = w_sel & bus.re & ~bus.we;
   assign w_wr_ctrl = w_wr & (bus.adr == 2'd0);
   assign w_wr_cnt  = w_wr & (bus.adr == 2'd1);
   assign w_wr_cmp  = w_wr & (bus.adr == 2'd2);
   assign w_wr_flg  = w_wr & (bus.adr == 2'd3);
   assign w_tick    = r_ctrl[0] & (r_pcnt == w_div_m1);

   always_comb begin
      w_div_m1 = 8'd0;
      case (r_ctrl[2:1])
         2'b00:   w_div_m1 = 8'd0;
         2'b01:   w_div_m1 = 8'd7;
         2'b10:   w_div_m1 = 8'd63;
         2'b11:   w_div_m1 = 8'd255;
         default: w_div_m1 = 8'd0;
      endcase
   end

   always_comb begin
      w_pcnt_nxt = r_pcnt;
      if (!r_ctrl[0] || w_wr_ctrl || w_tick) begin
         w_pcnt_nxt = 8'd0;
      end else begin
         w_pcnt_nxt = r_pcnt + 8'd1;
      end
   end

   // A CPU write to CNT overrides the tick; compares use the pre-edge CNT/CMP.
   always_comb begin
      w_cnt_nxt = r_cnt;
      w_ovf_set = 1'b0;
      w_cmf_set = 1'b0;
      if (w_wr_cnt) begin
         w_cnt_nxt = bus.wdata;
      end else if (w_tick) begin
         if (r_ctrl[3] && (r_cnt == r_cmp)) begin
            w_cnt_nxt = {DW{1'b0}};
            w_cmf_set = 1'b1;
         end else begin
            if (r_cnt == {DW{1'b1}}) begin
               w_cnt_nxt = {DW{1'b0}};
               w_ovf_set = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + {{(DW-1){1'b0}}, 1'b1};
            end
            w_cmf_set = (r_cnt == r_cmp);
         end
      end else begin
         w_cnt_nxt = r_cnt;
      end
   end

   assign w_ctrl_nxt = w_wr_ctrl ? bus.wdata[5:0] : r_ctrl;
   assign w_cmp_nxt  = w_wr_cmp  ? bus.wdata      : r_cmp;
   assign w_ovf_nxt  = w_ovf_set | (r_ovf & ~(w_wr_flg & bus.wdata[0]));
   assign w_cmf_nxt  = w_cmf_set | (r_cmf & ~(w_wr_flg & bus.wdata[1]));

   always_comb begin
      w_rd_mux = {DW{1'b0}};
      case (bus.adr)
         2'd0:    w_rd_mux = {{(DW-6){1'b0}}, r_ctrl};
         2'd1:    w_rd_mux = r_cnt;
         2'd2:    w_rd_mux = r_cmp;
         2'd3:    w_rd_mux = {{(DW-2){1'b0}}, r_cmf, r_ovf};
         default: w_rd_mux = {DW{1'b0}};
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_ctrl  <= 6'd0;
         r_cnt   <= {DW{1'b0}};
         r_cmp   <= {DW{1'b0}};
         r_ovf   <= 1'b0;
         r_cmf   <= 1'b0;
         r_pcnt  <= 8'd0;
         r_rdata <= {DW{1'b0}};
         r_irq   <= 1'b0;
         r_pwm   <= 1'b0;
      end else begin
         r_ctrl  <= w_ctrl_nxt;
         r_cnt   <= w_cnt_nxt;
         r_cmp   <= w_cmp_nxt;
         r_ovf   <= w_ovf_nxt;
         r_cmf   <= w_cmf_nxt;
         r_pcnt  <= w_pcnt_nxt;
         r_rdata <= w_rd ? w_rd_mux : r_rdata;
         r_irq   <= (w_ovf_nxt & w_ctrl_nxt[4]) | (w_cmf_nxt & w_ctrl_nxt[5]);
         r_pwm   <= w_ctrl_nxt[0] & (w_cnt_nxt < w_cmp_nxt);
      end
   end

   assign bus.rdata = r_rdata;
   assign o_irq     = r_irq;
   assign o_pwm     = r_pwm;
endmodule

// File: tb/tb_tmr_slave.sv
// Directed bench for tmr_slave: inputs change on falling edges, outputs are
// checked on falling edges against hand-computed values.
module tb_tmr_slave;
   logic clk;
   logic rst;
   logic irq;
   logic pwm;
   int   n_cmp;
   int   n_err;
   int   hi;

   tmr_slave_if #(.NSLAVES(4), .DW(8)) bus ();

   tmr_slave #(.ID(3), .NSLAVES(4), .DW(8)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus.slave),
      .o_irq (irq),
      .o_pwm (pwm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   task automatic wr_sel(input logic [3:0] s, input logic [1:0] a, input logic [7:0] d);
      bus.sel = s; bus.adr = a; bus.wdata = d; bus.we = 1'b1; bus.re = 1'b0;
      @(negedge clk);
      bus.sel = 4'b0000; bus.we = 1'b0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      wr_sel(4'b1000, a, d);
   endtask

   task automatic rd_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
      bus.sel = 4'b1000; bus.adr = a; bus.we = 1'b0; bus.re = 1'b1;
      @(negedge clk);
      bus.sel = 4'b0000; bus.re = 1'b0;
      chk(tag, bus.rdata, exp);
   endtask

   initial begin
      n_cmp = 0; n_err = 0;
      rst = 1'b0;
      bus.sel = 4'b0000; bus.adr = 2'd0; bus.we = 1'b0; bus.re = 1'b0; bus.wdata = 8'h00;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_rdata", bus.rdata, 8'h00);
      chk("rst_irq", {7'd0, irq}, 8'h00);
      chk("rst_pwm", {7'd0, pwm}, 8'h00);
      rd_chk("rst_ctrl", 2'd0, 8'h00);
      rd_chk("rst_cnt", 2'd1, 8'h00);
      rd_chk("rst_cmp", 2'd2, 8'h00);
      rd_chk("rst_flags", 2'd3, 8'h00);

      // Access through another slave's select is ignored.
      wr_sel(4'b0001, 2'd1, 8'h77);
      rd_chk("foreign_sel", 2'd1, 8'h00);

      // Free-run /1 overflow with OVIE.
      wr(2'd1, 8'hFD);
      wr(2'd0, 8'h11);
      rd_chk("ovf_fd", 2'd1, 8'hFD);
      chk("ovf_irq_lo", {7'd0, irq}, 8'h00);
      rd_chk("ovf_fe", 2'd1, 8'hFE);
      rd_chk("ovf_ff", 2'd1, 8'hFF);
      chk("ovf_irq_hi", {7'd0, irq}, 8'h01);
      chk("ovf_pwm_cmp0", {7'd0, pwm}, 8'h00);
      rd_chk("ovf_flags", 2'd3, 8'h01);
      wr(2'd3, 8'h01);
      chk("ovf_w1c_irq", {7'd0, irq}, 8'h00);
      wr(2'd0, 8'h00);
      repeat (3) @(negedge clk);
      rd_chk("freeze_cnt", 2'd1, 8'h03);

      // Prescale /8 and restart on CTRL rewrite.
      wr(2'd1, 8'h00);
      wr(2'd3, 8'h03);
      wr(2'd0, 8'h03);
      repeat (80) @(negedge clk);
      rd_chk("ps8_80clk", 2'd1, 8'd10);
      wr(2'd0, 8'h03);
      repeat (7) @(negedge clk);
      rd_chk("ps8_restart_a", 2'd1, 8'd10);
      rd_chk("ps8_restart_b", 2'd1, 8'd11);
      wr(2'd0, 8'h00);

      // Clear-on-compare with CMIE.
      wr(2'd1, 8'h00);
      wr(2'd2, 8'h04);
      wr(2'd3, 8'h03);
      wr(2'd0, 8'h29);
      rd_chk("coc_0", 2'd1, 8'h00);
      rd_chk("coc_1", 2'd1, 8'h01);
      rd_chk("coc_2", 2'd1, 8'h02);
      rd_chk("coc_3", 2'd1, 8'h03);
      chk("coc_irq_lo", {7'd0, irq}, 8'h00);
      rd_chk("coc_4", 2'd1, 8'h04);
      chk("coc_irq_hi", {7'd0, irq}, 8'h01);
      rd_chk("coc_wrap", 2'd1, 8'h00);
      rd_chk("coc_flags", 2'd3, 8'h02);
      wr(2'd0, 8'h00);
      wr(2'd3, 8'h03);

      // PWM duty: CMP=0x40 gives 64 of 256, CMP=0 gives none.
      wr(2'd2, 8'h40);
      wr(2'd1, 8'h00);
      wr(2'd0, 8'h01);
      hi = 0;
      for (int i = 0; i < 256; i++) begin
         hi += int'(pwm);
         @(negedge clk);
      end
      chk("pwm_duty_40", hi[7:0], 8'd64);
      chk("pwm_duty_40_hi", hi[15:8], 8'd0);
      wr(2'd2, 8'h00);
      hi = 0;
      for (int i = 0; i < 256; i++) begin
         hi += int'(pwm);
         @(negedge clk);
      end
      chk("pwm_cmp0", hi[7:0], 8'd0);

      // CNT write on a tick edge that would otherwise overflow.
      wr(2'd0, 8'h00);
      wr(2'd3, 8'h03);
      wr(2'd2, 8'h80);
      wr(2'd1, 8'hFE);
      wr(2'd0, 8'h01);
      @(negedge clk);
      wr(2'd1, 8'h20);
      rd_chk("cntwr_flags", 2'd3, 8'h00);
      rd_chk("cntwr_cnt", 2'd1, 8'h21);

      // W1C of OVF on the overflow edge: set wins.
      wr(2'd0, 8'h00);
      wr(2'd1, 8'hFF);
      wr(2'd0, 8'h01);
      wr(2'd3, 8'h01);
      rd_chk("w1c_vs_set", 2'd3, 8'h01);

      // Asynchronous reset mid-count.
      wr(2'd0, 8'h11);
      chk("pre_rst_irq", {7'd0, irq}, 8'h01);
      chk("pre_rst_pwm", {7'd0, pwm}, 8'h01);
      #2 rst = 1'b0;
      #1;
      chk("arst_rdata", bus.rdata, 8'h00);
      chk("arst_irq", {7'd0, irq}, 8'h00);
      chk("arst_pwm", {7'd0, pwm}, 8'h00);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rd_chk("arst_ctrl", 2'd0, 8'h00);
      rd_chk("arst_cnt", 2'd1, 8'h00);
      rd_chk("arst_cmp", 2'd2, 8'h00);
      rd_chk("arst_flags", 2'd3, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
